// File: rtl/ps2_tx_if.sv
// ps2_tx_if: command-byte handshake between a requester and the PS/2 host transmitter.
// The requester (master) offers a byte with i_valid/i_data; the transmitter (slave)
// reports o_ready/o_busy and ends each accepted transfer with a one-cycle o_done/o_err.
interface ps2_tx_if;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  modport master (
    output i_valid,
    output i_data,
    input  o_ready,
    input  o_busy,
    input  o_done,
    input  o_err
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_ready,
    output o_busy,
    output o_done,
    output o_err
  );
endinterface

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device transmitter. Performs the request-to-send sequence
// (clock inhibit, start bit), shifts out 8 data bits LSB first, odd parity and stop
// on device clock falling edges, then samples the device ACK.
// Optional: define PS2_TX_TIMEOUT_EN to enable the transfer watchdog (TIMEOUT_CYCLES).
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_ps2_clk,
  input  logic    i_ps2_data,
  output logic    o_ps2_clk_oe,
  output logic    o_ps2_data_oe,
  ps2_tx_if.slave bus
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned FltW = $clog2(FILTER_LEN + 1);
  localparam logic [InhW-1:0] InhLast   = InhW'(INHIBIT_CYCLES - 1);
  // Only reachable when INHIBIT_CYCLES >= 2; the InhLast test is evaluated first.
  localparam logic [InhW-1:0] InhPenult = InhW'(INHIBIT_CYCLES - 2);
  localparam logic [FltW-1:0] FiltLast  = FltW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StSend,
    StAck,
    StWaitIdle
  } state_e;

  state_e state_q, state_d;

  logic [1:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic            clk_filt_q;
  logic [FltW-1:0] filt_cnt_q;
  logic            clk_fall_q;

  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            err_out_q, err_out_d;
  logic            ready;
  logic            accept;
  logic            wd_hit;

  // Synchronize both lines and debounce the clock; clk_fall_q pulses on an accepted 1->0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
      clk_fall_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], i_ps2_clk};
      data_sync_q <= {data_sync_q[0], i_ps2_data};
      clk_fall_q  <= 1'b0;
      if (clk_sync_q[1] == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltLast) begin
        filt_cnt_q <= '0;
        clk_filt_q <= clk_sync_q[1];
        clk_fall_q <= clk_filt_q;
      end else begin
        filt_cnt_q <= filt_cnt_q + FltW'(1);
      end
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           wd_active;

  // Watchdog runs only once the device is expected to be clocking.
  always_comb begin
    wd_active = (state_q == StSend) || (state_q == StAck) || (state_q == StWaitIdle);
    wd_d      = wd_active ? wd_q + WdW'(1) : '0;
    wd_hit    = wd_active && (wd_q == WdLast);
  end

  // Watchdog counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  // Ready is held low during the done pulse so a new byte starts the cycle after.
  assign ready  = (state_q == StIdle) && !done_q;
  assign accept = bus.i_valid && ready;

  // Next-state and registered-output logic for the transfer sequence.
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    err_d     = err_q;
    done_d    = 1'b0;
    err_out_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (accept) begin
          state_d   = StInhibit;
          inh_cnt_d = '0;
          shift_d   = {1'b1, ~^bus.i_data, bus.i_data};
          bit_cnt_d = '0;
          err_d     = 1'b0;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES == 1);
        end
      end
      StInhibit: begin
        if (inh_cnt_q == InhLast) begin
          state_d   = StSend;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
        end else begin
          inh_cnt_d = inh_cnt_q + InhW'(1);
          // Start bit goes low in the final inhibit cycle.
          if (inh_cnt_q == InhPenult) begin
            data_oe_d = 1'b1;
          end
        end
      end
      StSend: begin
        if (clk_fall_q) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        if (clk_fall_q) begin
          err_d   = data_sync_q[1];
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (clk_filt_q && data_sync_q[1]) begin
          done_d    = 1'b1;
          err_out_d = err_q;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase

    if (wd_hit) begin
      state_d   = StIdle;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b1;
      err_out_d = 1'b1;
    end
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      inh_cnt_q <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      err_q     <= err_d;
      done_q    <= done_d;
      err_out_q <= err_out_d;
    end
  end

  assign o_ps2_clk_oe  = clk_oe_q;
  assign o_ps2_data_oe = data_oe_q;
  assign bus.o_ready   = ready;
  assign bus.o_busy    = ~ready;
  assign bus.o_done    = done_q;
  assign bus.o_err     = err_out_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: scoreboard bench for ps2_tx with a behavioural PS/2 device model.
// Expected frames and done/err results are queued when a byte is issued; the device
// model and the done monitor pop and compare independently.
module tb_ps2_tx;
  localparam int unsigned INH = 20;
  localparam int unsigned FLT = 2;
  localparam int unsigned TMO = 5000;
`ifdef PS2_TX_TIMEOUT_EN
  // Shorter device clock so a full frame fits inside the watchdog window.
  localparam int HALF = 150;
`else
  localparam int HALF = 500;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch_low   = 1'b0;
  logic o_clk_oe;
  logic o_data_oe;
  logic ps2_clk_line;
  logic ps2_data_line;

  int errors = 0;
  int checks = 0;

  bit         exp_done_q[$];
  logic [10:0] exp_frame_q[$];

  bit dev_ack    = 1'b1;
  bit dev_silent = 1'b0;
  bit dev_glitch = 1'b0;
  bit dev_abort  = 1'b0;
  bit dev_busy   = 1'b0;
  int dev_bit    = 0;
  int done_seen  = 0;
  bit chk_ready_next = 1'b0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_line  = ~(o_clk_oe | dev_clk_low | glitch_low);
  assign ps2_data_line = ~(o_data_oe | dev_data_low);

  ps2_tx_if bus ();

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk    (ps2_clk_line),
    .i_ps2_data   (ps2_data_line),
    .o_ps2_clk_oe (o_clk_oe),
    .o_ps2_data_oe(o_data_oe),
    .bus          (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    while (bus.o_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", bus.o_ready, 1);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("ready_fall_after_accept", bus.o_ready, 0);
    check("clk_oe_rise_after_accept", o_clk_oe, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_done_q.size() != 0 || exp_frame_q.size() != 0 || dev_busy ||
            bus.o_ready !== 1'b1) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("xfer_complete_in_time", (n < 30000), 1);
  endtask

  // Done monitor: every o_done pulse must match a queued expectation.
  initial begin : monitor
    bit e;
    forever begin
      @(negedge clk);
      if (chk_ready_next) begin
        check("ready_after_done", bus.o_ready, 1);
        chk_ready_next = 1'b0;
      end
      if (rst_n === 1'b1 && bus.o_done === 1'b1) begin
        done_seen++;
        check("busy_during_done", bus.o_busy, 1);
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual o_done=1 required o_done=0");
        end else begin
          e = exp_done_q.pop_front();
          check("done_err", bus.o_err, e);
        end
        chk_ready_next = 1'b1;
      end
    end
  end

  // Device model: measures the inhibit, clocks the frame in, samples on rising edges, ACKs.
  initial begin : device
    logic [10:0] got;
    int inh;
    logic prev_d;
    logic last_d;
    bit aborted;
    forever begin
      wait (o_clk_oe === 1'b1);
      dev_busy = 1'b1;
      dev_bit  = 0;
      inh      = 0;
      prev_d   = 1'b1;
      last_d   = 1'b1;
      aborted  = 1'b0;
      got      = '0;
      while (o_clk_oe === 1'b1) begin
        @(negedge clk);
        if (o_clk_oe === 1'b1) begin
          inh++;
          prev_d = last_d;
          last_d = ps2_data_line;
        end
      end
      check("inhibit_len", inh, INH);
      check("data_high_before_last_inhibit", prev_d, 1);
      check("data_low_in_last_inhibit", last_d, 0);
      got[0] = ps2_data_line;
      if (!dev_silent) begin
        wait_cyc(20);
        for (int i = 0; i < 10 && !aborted; i++) begin
          dev_bit     = i;
          dev_clk_low = 1'b1;
          wait_cyc(HALF);
          dev_clk_low = 1'b0;
          got[i+1]    = ps2_data_line;
          if (dev_glitch && i == 4) begin
            wait_cyc(HALF / 2);
            glitch_low = 1'b1;
            wait_cyc(1);
            glitch_low = 1'b0;
            wait_cyc(HALF - HALF / 2 - 1);
          end else begin
            wait_cyc(HALF);
          end
          if (dev_abort) aborted = 1'b1;
        end
        if (!aborted) begin
          dev_data_low = dev_ack;
          wait_cyc(10);
          dev_clk_low = 1'b1;
          wait_cyc(HALF);
          dev_clk_low = 1'b0;
          wait_cyc(10);
          dev_data_low = 1'b0;
          wait_cyc(HALF);
          if (exp_frame_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: actual frame=%0h required none", got);
          end else begin
            check("frame", got, exp_frame_q.pop_front());
          end
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
      end
      dev_busy = 1'b0;
    end
  end

  initial begin : stimulus
    int n;
    int seen;
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    wait_cyc(3);
    @(negedge clk);
    check("rst_ready", bus.o_ready, 1);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_err", bus.o_err, 0);
    check("rst_clk_oe", o_clk_oe, 0);
    check("rst_data_oe", o_data_oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(5);

    // 0xED: six ones -> parity 1. Frame is {stop, parity, data, start}, start at bit 0.
    exp_frame_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
    exp_done_q.push_back(1'b0);
    send(8'hED);
    wait_idle();

    // 0x01: one one -> parity 0; a 1-cycle clock glitch lands in a high phase.
    dev_glitch = 1'b1;
    exp_frame_q.push_back({1'b1, 1'b0, 8'h01, 1'b0});
    exp_done_q.push_back(1'b0);
    send(8'h01);
    wait_idle();
    dev_glitch = 1'b0;

    // 0xFF: eight ones -> parity 1.
    exp_frame_q.push_back({1'b1, 1'b1, 8'hFF, 1'b0});
    exp_done_q.push_back(1'b0);
    send(8'hFF);
    wait_idle();

    // 0x3C with device NACK: four ones -> parity 1, err expected.
    dev_ack = 1'b0;
    exp_frame_q.push_back({1'b1, 1'b1, 8'h3C, 1'b0});
    exp_done_q.push_back(1'b1);
    send(8'h3C);
    wait_idle();
    check("nack_clk_oe_released", o_clk_oe, 0);
    check("nack_data_oe_released", o_data_oe, 0);
    dev_ack = 1'b1;

    // 0xF4 (five ones -> parity 0) with a 0x55 request mid-transfer that must be dropped.
    exp_frame_q.push_back({1'b1, 1'b0, 8'hF4, 1'b0});
    exp_done_q.push_back(1'b0);
    send(8'hF4);
    wait_cyc(2000);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h55;
    @(negedge clk);
    bus.i_valid = 1'b0;
    wait_idle();
    wait_cyc(50);
    @(negedge clk);
    check("no_requeue_clk_oe", o_clk_oe, 0);
    check("no_requeue_ready", bus.o_ready, 1);

    // Reset mid-SEND: 0x01 bit 3 is 0, so data is being pulled low when reset hits.
    send(8'h01);
    n = 0;
    while (dev_bit < 3 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit3", (dev_bit >= 3), 1);
    wait_cyc(50);
    @(negedge clk);
    check("data_oe_before_reset", o_data_oe, 1);
    dev_abort = 1'b1;
    seen = done_seen;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_clk_oe", o_clk_oe, 0);
    check("async_rst_data_oe", o_data_oe, 0);
    check("async_rst_ready", bus.o_ready, 1);
    check("async_rst_busy", bus.o_busy, 0);
    check("async_rst_done", bus.o_done, 0);
    n = 0;
    while (dev_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst_n     = 1'b1;
    dev_abort = 1'b0;
    wait_cyc(100);
    check("no_done_after_reset", done_seen, seen);

    // Device never clocks.
    dev_silent = 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
    exp_done_q.push_back(1'b1);
`endif
    send(8'hED);
    n = 0;
    while (o_clk_oe === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_released", o_clk_oe, 0);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (bus.o_done !== 1'b1 && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TMO);
    check("timeout_clk_oe", o_clk_oe, 0);
    check("timeout_data_oe", o_data_oe, 0);
    wait_idle();
`else
    wait_cyc(TMO + 1000);
    @(negedge clk);
    check("stuck_busy", bus.o_busy, 1);
    check("stuck_data_oe", o_data_oe, 1);
    check("stuck_clk_oe", o_clk_oe, 0);
    rst_n = 1'b0;
    wait_cyc(3);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(5);
`endif
    dev_silent = 1'b0;
    check("leftover_expectations", exp_done_q.size() + exp_frame_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to an attached keyboard over the same open-drain PS/2 clock/data pair that the PS/2 receiver listens on. It performs the host request-to-send sequence, shifts out 8 data bits LSB first plus odd parity and stop, checks the device ACK bit, and reports completion or error. It sits beside the receiver in the PS/2 subsystem. The receiver must ignore the bus while `o_busy` is high.

## Interface
- `INHIBIT_CYCLES`, 5000: clock-low inhibit duration in `i_clk` cycles (100 µs at 50 MHz).
- `FILTER_LEN`, 8: consecutive identical samples required to accept a new filtered level on PS/2 clock.
- `TIMEOUT_CYCLES`, 1000000: transfer watchdog in `i_clk` cycles (20 ms at 50 MHz).

Ports:
- `i_clk` in 1: system clock; all logic rising-edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_ps2_clk` in 1: raw PS/2 clock line level.
- `i_ps2_data` in 1: raw PS/2 data line level.
- `o_ps2_clk_oe` out 1: 1 = pull PS/2 clock low; 0 = release (pull-up).
- `o_ps2_data_oe` out 1: 1 = pull PS/2 data low; 0 = release.
- `i_valid` in 1: command byte request.
- `i_data` in 8: command byte; bit 0 is transmitted first.
- `o_ready` out 1: idle, able to accept a byte.
- `o_busy` out 1: transfer in progress (`~o_ready`).
- `o_done` out 1: one-cycle pulse at end of every accepted transfer.
- `o_err` out 1: valid only with `o_done`; 1 = NACK or timeout.

## Operation
- Inputs pass through a 2-flop synchronizer. Clock then passes through the `FILTER_LEN` filter. A falling edge is filtered 1→0.
- Accept happens when `i_valid & o_ready`. The block latches frame {stop=1, parity, `i_data`[7:0]} into a 10-bit shift register. Parity = ~^`i_data`, i.e. odd parity. `i_valid` while busy is ignored, not queued.
- FSM states:
  - IDLE: both oe=0, `o_ready`=1. On accept → INHIBIT, counter cleared.
  - INHIBIT: `o_ps2_clk_oe`=1 for `INHIBIT_CYCLES` cycles. In the last cycle, `o_ps2_data_oe`=1 (start bit). → SEND.
  - SEND: `o_ps2_clk_oe`=0 and `o_ps2_data_oe` stays 1. On each filtered falling edge, drive `o_ps2_data_oe` = ~shift[0], shift right, and bit_cnt++. Once the 10th bit (stop, data released) has been presented → ACK.
  - ACK: on the next filtered falling edge, sample synchronized data. 0 = ACK; 1 = NACK, which sets the err flag. → WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clock and synchronized data are both 1. Then pulse `o_done`, with `o_err` = err flag. → IDLE.
- Reset, async: state IDLE, `o_ps2_clk_oe`=0, `o_ps2_data_oe`=0, `o_ready`=1, `o_busy`=0, `o_done`=0, `o_err`=0. Filter and synchronizer are preset to 1. Asserting reset mid-transfer releases both lines immediately and issues no `o_done`.

## Timing
- `o_ready` falls the cycle after accept. `o_ps2_clk_oe` rises the cycle after accept.
- Clock low lasts exactly `INHIBIT_CYCLES` cycles. Data goes low in the final inhibit cycle, before clock is released.
- Each data bit changes 2+`FILTER_LEN`+1 cycles after the raw clock falls, which is well inside the device's clock-low half period.
- `o_done` and `o_err` are asserted together for exactly one cycle. `o_ready` returns to 1 in the following cycle.
- A new accept is possible on the first cycle `o_ready`=1.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - The watchdog counts from entering SEND.
  - Reaching `TIMEOUT_CYCLES` in any state other than IDLE or INHIBIT releases both lines the next cycle, pulses `o_done` with `o_err`=1, and returns to IDLE.
  - The watchdog is cleared in IDLE.
- `PS2_TX_TIMEOUT_EN` undefined: no watchdog. The block waits indefinitely for device clocks, and `o_err` reports NACK only.

## Test plan
Bench parameters: `INHIBIT_CYCLES`=20, `FILTER_LEN`=2, `TIMEOUT_CYCLES`=5000. The device model clocks at 1000-cycle period, samples on rising edges and drives ACK.
- Send 0xED with device ACK → observed line bits 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1; one `o_done` with `o_err`=0; clock-low inhibit exactly 20 cycles.
- Send 0x01 → parity bit 0. Send 0xFF → parity bit 1. Both complete with `o_err`=0.
- Device leaves data high at the ACK edge → `o_done`=1 and `o_err`=1; both oe=0 afterward.
- With `PS2_TX_TIMEOUT_EN` defined and the device never clocking → `o_done` with `o_err`=1 after 5000 cycles in SEND; lines released. Without the macro, the block remains busy.
- Pulse `i_valid` with 0x55 mid-transfer of 0xF4 → only 0xF4 is sent, one `o_done`. Assert `i_rst_n`=0 mid-SEND → both oe drop asynchronously, `o_ready`=1, no `o_done`.
- Inject a 1-cycle low glitch on the clock during SEND → no bit advance, and the frame is still correct.
